// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the CPU control unit and its surroundings: run request,
// instruction ROM, register file, ALU, data memory and the status outputs.
// The control unit connects through the master modport; the instruction ROM,
// register file, ALU and data memory connect through the slave modport.
interface cpu_control_unit_if #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
);
    logic              run;

    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;

    logic [1:0]        rf_raddr_a;
    logic [1:0]        rf_raddr_b;
    logic [DATA_W-1:0] rf_rdata_a;
    logic              rf_we;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              dmem_cs;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;
    logic              illegal_op;

    modport master (
        input  run, imem_data, rf_rdata_a, alu_result, dmem_rdata, dmem_ready,
        output imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_op, dmem_cs, dmem_we, dmem_addr, dmem_wdata,
               pc, busy, halted, illegal_op
    );

    modport slave (
        output run, imem_data, rf_rdata_a, alu_result, dmem_rdata, dmem_ready,
        input  imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_op, dmem_cs, dmem_we, dmem_addr, dmem_wdata,
               pc, busy, halted, illegal_op
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for a tiny 4-register accumulator-style CPU.
// Each instruction walks FETCH -> DECODE -> EXEC (and MEM for loads/stores).
// The instruction ROM is synchronous, so the word addressed in FETCH is
// captured into ir during DECODE. Strobes are decoded from the registered
// state and instruction and are masked while reset is asserted.
module cpu_control_unit #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    cpu_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic              illegal_q;
    logic              halted_q;
    logic              busy_q;

    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   addr;

    logic              rf_we_c;
    logic [DATA_W-1:0] rf_wdata_c;
    logic              dmem_cs_c;
    logic              dmem_we_c;

    assign op      = ir[15:12];
    assign rd      = ir[11:10];
    assign rs      = ir[9:8];
    assign imm_ext = DATA_W'(ir[7:0]);
    assign addr    = ir[PC_W-1:0];

    // Sequencer: state, program counter, instruction register and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc <= '0;
                    if (bus.run) begin
                        state  <= S_FETCH;
                        busy_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= bus.imem_data;
                    pc    <= pc + PC_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_NOP, OP_LDI, OP_ADD, OP_SUB: begin
                            state <= S_FETCH;
                        end
                        OP_LD, OP_ST: begin
                            state <= S_MEM;
                        end
                        OP_JMP: begin
                            pc    <= addr;
                            state <= S_FETCH;
                        end
                        OP_HALT: begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                        default: begin
                            illegal_q <= 1'b1;
                            state     <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobe and write-data decode; reset masks every strobe regardless of state.
    always_comb begin
        rf_we_c    = 1'b0;
        rf_wdata_c = bus.alu_result;
        dmem_cs_c  = 1'b0;
        dmem_we_c  = 1'b0;
        case (state)
            S_EXEC: begin
                if (op == OP_LDI) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = imm_ext;
                end else if (op == OP_ADD || op == OP_SUB) begin
                    rf_we_c = 1'b1;
                end
            end
            S_MEM: begin
                dmem_cs_c = 1'b1;
                dmem_we_c = (op == OP_ST);
                if (op == OP_LD && bus.dmem_ready) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = bus.dmem_rdata;
                end
            end
            default: begin
                rf_we_c = 1'b0;
            end
        endcase
        if (reset) begin
            rf_we_c   = 1'b0;
            dmem_cs_c = 1'b0;
            dmem_we_c = 1'b0;
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.rf_raddr_a = rd;
    assign bus.rf_raddr_b = rs;
    assign bus.rf_we      = rf_we_c;
    assign bus.rf_waddr   = rd;
    assign bus.rf_wdata   = rf_wdata_c;
    assign bus.alu_op     = (op == OP_SUB);
    assign bus.dmem_cs    = dmem_cs_c;
    assign bus.dmem_we    = dmem_we_c;
    assign bus.dmem_addr  = addr;
    assign bus.dmem_wdata = bus.rf_rdata_a;
    assign bus.pc         = pc;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: small programs run against models of
// the instruction ROM, register file, ALU and data memory, with outputs
// checked at the falling edge against hand-computed cycle-by-cycle values.
module tb_cpu_control_unit;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   cyc;

    logic [15:0] rom  [16];
    logic [7:0]  regs [4];
    logic [7:0]  dmem [16];

    cpu_control_unit_if #(.PC_W(4), .DATA_W(8)) bus ();

    cpu_control_unit #(.PC_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction ROM: data appears the cycle after the address.
    always @(posedge clk) begin
        bus.imem_data <= rom[bus.imem_addr];
    end

    // Register file with combinational reads, cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (bus.rf_we) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    // Data memory written on a completed store, cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) dmem[i] <= '0;
        end else if (bus.dmem_cs && bus.dmem_we && bus.dmem_ready) begin
            dmem[bus.dmem_addr] <= bus.dmem_wdata;
        end
    end

    assign bus.rf_rdata_a = regs[bus.rf_raddr_a];
    assign bus.alu_result = bus.alu_op ? (regs[bus.rf_raddr_a] - regs[bus.rf_raddr_b])
                                       : (regs[bus.rf_raddr_a] + regs[bus.rf_raddr_b]);
    assign bus.dmem_rdata = dmem[bus.dmem_addr];

    task automatic applyStimulus(input logic rst, input logic rn, input logic rdy);
        reset          = rst;
        bus.run        = rn;
        bus.dmem_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic goTo(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clearRom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic startProgram(input logic rdy);
        applyStimulus(1'b1, 1'b0, rdy);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, rdy);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, rdy);
        cyc = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        clearRom();

        // Program 1: LDI R1,2; LDI R2,4; ADD R1,R2; HALT
        $display("[TB] program 1: LDI/LDI/ADD/HALT");
        rom[0] = 16'h1402;
        rom[1] = 16'h1804;
        rom[2] = 16'h2600;
        rom[3] = 16'h7000;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy",   32'(bus.busy),       32'd0);
        checkOutput("rst_pc",     32'(bus.pc),         32'd0);
        checkOutput("rst_halted", 32'(bus.halted),     32'd0);
        checkOutput("rst_illeg",  32'(bus.illegal_op), 32'd0);
        checkOutput("rst_rfwe",   32'(bus.rf_we),      32'd0);
        checkOutput("rst_cs",     32'(bus.dmem_cs),    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("idle_busy",  32'(bus.busy),       32'd0);
        checkOutput("idle_pc",    32'(bus.pc),         32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cyc = 0;
        goTo(1);
        checkOutput("p1_fetch_busy", 32'(bus.busy),      32'd1);
        checkOutput("p1_fetch_ia",   32'(bus.imem_addr), 32'd0);
        goTo(3);
        checkOutput("p1_c3_we",    32'(bus.rf_we),    32'd1);
        checkOutput("p1_c3_waddr", 32'(bus.rf_waddr), 32'd1);
        checkOutput("p1_c3_wdata", 32'(bus.rf_wdata), 32'h02);
        checkOutput("p1_c3_cs",    32'(bus.dmem_cs),  32'd0);
        goTo(6);
        checkOutput("p1_c6_waddr", 32'(bus.rf_waddr), 32'd2);
        checkOutput("p1_c6_wdata", 32'(bus.rf_wdata), 32'h04);
        goTo(9);
        checkOutput("p1_c9_we",    32'(bus.rf_we),    32'd1);
        checkOutput("p1_c9_waddr", 32'(bus.rf_waddr), 32'd1);
        checkOutput("p1_c9_wdata", 32'(bus.rf_wdata), 32'h06);
        checkOutput("p1_c9_aluop", 32'(bus.alu_op),   32'd0);
        goTo(13);
        checkOutput("p1_halted", 32'(bus.halted), 32'd1);
        checkOutput("p1_busy",   32'(bus.busy),   32'd0);
        checkOutput("p1_pc",     32'(bus.pc),     32'd4);
        goTo(16);
        checkOutput("p1_stay_halted", 32'(bus.halted), 32'd1);
        checkOutput("p1_stay_rfwe",   32'(bus.rf_we),  32'd0);
        checkOutput("p1_stay_cs",     32'(bus.dmem_cs), 32'd0);
        checkOutput("p1_stay_pc",     32'(bus.pc),     32'd4);
        checkOutput("p1_r1",          32'(regs[1]),    32'h06);
        checkOutput("p1_r2",          32'(regs[2]),    32'h04);

        // Program 2: LDI R1,5; LDI R2,0x0E; SUB R1,R2 -> 0xF7
        $display("[TB] program 2: SUB wrap");
        clearRom();
        rom[0] = 16'h1405;
        rom[1] = 16'h180E;
        rom[2] = 16'h3600;
        rom[3] = 16'h7000;
        startProgram(1'b1);
        goTo(3);
        checkOutput("p2_c3_wdata", 32'(bus.rf_wdata), 32'h05);
        goTo(9);
        checkOutput("p2_sub_we",    32'(bus.rf_we),    32'd1);
        checkOutput("p2_sub_waddr", 32'(bus.rf_waddr), 32'd1);
        checkOutput("p2_sub_wdata", 32'(bus.rf_wdata), 32'hF7);
        checkOutput("p2_sub_aluop", 32'(bus.alu_op),   32'd1);

        // Program 3: LDI R1,0x5A; ST R1,6 (3 wait cycles); LD R3,6; HALT
        $display("[TB] program 3: store with wait states, then load");
        clearRom();
        rom[0] = 16'h145A;
        rom[1] = 16'h5406;
        rom[2] = 16'h4C06;
        rom[3] = 16'h7000;
        startProgram(1'b0);
        goTo(3);
        checkOutput("p3_ldi_wdata", 32'(bus.rf_wdata), 32'h5A);
        for (int k = 7; k <= 10; k++) begin
            goTo(k);
            if (k == 10) applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("p3_st_cs",    32'(bus.dmem_cs),    32'd1);
            checkOutput("p3_st_we",    32'(bus.dmem_we),    32'd1);
            checkOutput("p3_st_addr",  32'(bus.dmem_addr),  32'h6);
            checkOutput("p3_st_wdata", 32'(bus.dmem_wdata), 32'h5A);
            checkOutput("p3_st_rfwe",  32'(bus.rf_we),      32'd0);
            checkOutput("p3_st_busy",  32'(bus.busy),       32'd1);
        end
        goTo(11);
        checkOutput("p3_fetch_cs", 32'(bus.dmem_cs),   32'd0);
        checkOutput("p3_fetch_ia", 32'(bus.imem_addr), 32'd2);
        goTo(14);
        checkOutput("p3_ld_cs",    32'(bus.dmem_cs),  32'd1);
        checkOutput("p3_ld_we",    32'(bus.dmem_we),  32'd0);
        checkOutput("p3_ld_rfwe",  32'(bus.rf_we),    32'd1);
        checkOutput("p3_ld_waddr", 32'(bus.rf_waddr), 32'd3);
        checkOutput("p3_ld_wdata", 32'(bus.rf_wdata), 32'h5A);
        goTo(15);
        checkOutput("p3_r3",    32'(regs[3]), 32'h5A);
        checkOutput("p3_mem6",  32'(dmem[6]), 32'h5A);

        // Program 4a: JMP 0xF at 0, JMP 0x0 at 15 -> endless loop
        $display("[TB] program 4a: JMP loop through pc 15");
        clearRom();
        rom[0]  = 16'h600F;
        rom[15] = 16'h6000;
        startProgram(1'b1);
        goTo(3);
        checkOutput("p4a_c3_pc",  32'(bus.pc), 32'd1);
        goTo(4);
        checkOutput("p4a_c4_pc",  32'(bus.pc), 32'd15);
        goTo(6);
        checkOutput("p4a_c6_pc",  32'(bus.pc), 32'd0);
        goTo(10);
        checkOutput("p4a_c10_pc", 32'(bus.pc), 32'd15);
        goTo(12);
        checkOutput("p4a_c12_pc",     32'(bus.pc),     32'd0);
        checkOutput("p4a_c12_halted", 32'(bus.halted), 32'd0);
        checkOutput("p4a_c12_busy",   32'(bus.busy),   32'd1);

        // Program 4b: JMP 0xF at 0, NOP at 15 -> pc wraps to 0
        $display("[TB] program 4b: plain wrap at pc 15");
        clearRom();
        rom[0] = 16'h600F;
        startProgram(1'b1);
        goTo(4);
        checkOutput("p4b_c4_pc",  32'(bus.pc), 32'd15);
        goTo(6);
        checkOutput("p4b_c6_pc",  32'(bus.pc), 32'd0);
        goTo(7);
        checkOutput("p4b_c7_ia",  32'(bus.imem_addr), 32'd0);
        goTo(10);
        checkOutput("p4b_c10_pc",     32'(bus.pc),     32'd15);
        checkOutput("p4b_c10_halted", 32'(bus.halted), 32'd0);

        // Program 5: illegal 0xA, LDI R0,0x33, HALT
        $display("[TB] program 5: illegal opcode");
        clearRom();
        rom[0] = 16'hA000;
        rom[1] = 16'h1033;
        rom[2] = 16'h7000;
        startProgram(1'b1);
        goTo(3);
        checkOutput("p5_ex_rfwe",  32'(bus.rf_we),      32'd0);
        checkOutput("p5_ex_cs",    32'(bus.dmem_cs),    32'd0);
        checkOutput("p5_ex_we",    32'(bus.dmem_we),    32'd0);
        checkOutput("p5_ex_illeg", 32'(bus.illegal_op), 32'd0);
        goTo(4);
        checkOutput("p5_c4_illeg", 32'(bus.illegal_op), 32'd1);
        checkOutput("p5_c4_busy",  32'(bus.busy),       32'd1);
        goTo(6);
        checkOutput("p5_ldi_we",    32'(bus.rf_we),      32'd1);
        checkOutput("p5_ldi_waddr", 32'(bus.rf_waddr),   32'd0);
        checkOutput("p5_ldi_wdata", 32'(bus.rf_wdata),   32'h33);
        checkOutput("p5_ldi_illeg", 32'(bus.illegal_op), 32'd1);
        goTo(10);
        checkOutput("p5_halted", 32'(bus.halted),     32'd1);
        checkOutput("p5_illeg",  32'(bus.illegal_op), 32'd1);

        // Program 6: illegal, LDI R1,0x5A, ST R1,6 stalled; reset mid-wait
        $display("[TB] program 6: reset during memory wait");
        clearRom();
        rom[0] = 16'hA000;
        rom[1] = 16'h145A;
        rom[2] = 16'h5406;
        startProgram(1'b0);
        goTo(10);
        checkOutput("p6_mem_cs",    32'(bus.dmem_cs),    32'd1);
        checkOutput("p6_mem_illeg", 32'(bus.illegal_op), 32'd1);
        goTo(11);
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("p6_rst_cs",   32'(bus.dmem_cs), 32'd0);
        checkOutput("p6_rst_we",   32'(bus.dmem_we), 32'd0);
        checkOutput("p6_rst_rfwe", 32'(bus.rf_we),   32'd0);
        goTo(12);
        checkOutput("p6_after_busy",  32'(bus.busy),       32'd0);
        checkOutput("p6_after_pc",    32'(bus.pc),         32'd0);
        checkOutput("p6_after_illeg", 32'(bus.illegal_op), 32'd0);
        checkOutput("p6_after_cs",    32'(bus.dmem_cs),    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        goTo(14);
        checkOutput("p6_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("p6_idle_pc",   32'(bus.pc),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter PC_W, default 4, program-counter and data-address width.
REQ-002 Parameter DATA_W, default 8, register and data-memory word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level start request, sampled only in IDLE.
REQ-006 imem_addr  out  PC_W  instruction address, always equal to pc.
REQ-007 imem_data  in  16  instruction word, valid one cycle after imem_addr (synchronous ROM).
REQ-008 rf_raddr_a / rf_raddr_b  out  2 each  register-file read selects, = ir[11:10] / ir[9:8].
REQ-009 rf_rdata_a  in  DATA_W  register-file port A data (combinational read).
REQ-010 rf_we  out  1; rf_waddr  out  2; rf_wdata  out  DATA_W  register-file write port.
REQ-011 alu_op  out  1 (0 add, 1 sub); alu_result  in  DATA_W, combinational from rf ports A, B.
REQ-012 dmem_cs, dmem_we  out  1 each; dmem_addr  out  PC_W; dmem_wdata  out  DATA_W.
REQ-013 dmem_rdata  in  DATA_W; dmem_ready  in  1  access-complete handshake.
REQ-014 pc  out  PC_W; busy  out  1; halted  out  1; illegal_op  out  1 (sticky).

Function
REQ-015 Instruction fields: op=ir[15:12], rd=ir[11:10], rs=ir[9:8], imm=ir[7:0], addr=ir[PC_W-1:0].
REQ-016 Opcodes: 0 NOP, 1 LDI rd<=imm, 2 ADD rd<=rd+rs, 3 SUB rd<=rd-rs, 4 LD rd<=mem[addr], 5 ST mem[addr]<=rd, 6 JMP pc<=addr, 7 HALT; 8-15 illegal.
REQ-017 States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
REQ-018 IDLE: pc held 0; run=1 -> FETCH next cycle; busy=0.
REQ-019 FETCH: one cycle, unconditional -> DECODE.
REQ-020 DECODE: ir<=imem_data, pc<=pc+1 modulo 2^PC_W (15 wraps to 0); -> EXEC.
REQ-021 EXEC, LDI: rf_we=1, rf_waddr=rd, rf_wdata=imm[DATA_W-1:0]; -> FETCH.
REQ-022 EXEC, ADD/SUB: alu_op per opcode, rf_we=1, rf_waddr=rd, rf_wdata=alu_result (result wraps modulo 2^DATA_W); -> FETCH.
REQ-023 EXEC, JMP: pc<=addr, overriding DECODE increment; -> FETCH.
REQ-024 EXEC, LD/ST -> MEM; HALT -> HALT; NOP -> FETCH.
REQ-025 EXEC, illegal opcode: executed as NOP, illegal_op set to 1 and held until reset.
REQ-026 MEM: dmem_cs=1, dmem_addr=addr, dmem_we=1 for ST with dmem_wdata=rf_rdata_a; all held stable while dmem_ready=0.
REQ-027 MEM, LD with dmem_ready=1: rf_we=1, rf_waddr=rd, rf_wdata=dmem_rdata same cycle; -> FETCH.
REQ-028 MEM, ST with dmem_ready=1: -> FETCH; no rf write.
REQ-029 Latency: NOP/LDI/ADD/SUB/JMP 3 cycles; LD/ST 4 + N cycles, N = dmem_ready=0 wait cycles.
REQ-030 HALT: halted=1, busy=0, no strobes; run ignored; exit only via reset.
REQ-031 rf_we, dmem_cs, dmem_we SHALL be 0 in every state/opcode not listed above; never simultaneously rf write and dmem write.
REQ-032 busy=1 in FETCH, DECODE, EXEC, MEM.

Reset
REQ-033 reset=1 at any clock edge, any state (including MEM mid-wait): state<=IDLE, pc<=0, ir<=0, illegal_op<=0, halted<=0.
REQ-034 While reset=1: rf_we, dmem_cs, dmem_we forced 0 combinationally, regardless of state.
REQ-035 After reset deassert: IDLE until run=1.

Verification
REQ-036 ROM {LDI R1,0x02; LDI R2,0x04; ADD R1,R2; HALT}, run=1 -> writes R1=0x02, R2=0x04, R1=0x06 at cycles 3,6,9 after FETCH entry; halted=1 after 4th instruction, pc=4.
REQ-037 LDI R1,0x05; LDI R2,0x0E; SUB R1,R2 -> rf_wdata=0xF7 (wrap), alu_op=1 during write cycle.
REQ-038 ST R1,0x06 with dmem_ready held 0 for 3 cycles -> dmem_cs=dmem_we=1, addr=0x6, wdata stable 4 cycles; next FETCH after ready; LD R3,0x06 returns value into R3.
REQ-039 JMP 0x0 at pc=15 and plain execution at pc=15 -> pc becomes 0 both cases; loop repeats without halt.
REQ-040 Opcode 0xA -> illegal_op=1, no rf/dmem strobe, execution continues; stays 1 across later instructions.
REQ-041 reset pulsed during MEM wait -> dmem_cs=0 that cycle, next cycle IDLE, pc=0, busy=0, illegal_op=0.
